// File: rtl/booth_mul_ctrl_if.sv
// ----------------------------------------------------------------------------
// booth_mul_ctrl_if : operand/result handshake bundle for booth_mul_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface booth_mul_ctrl_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

`default_nettype wire

// File: rtl/booth_mul_ctrl.sv
// ----------------------------------------------------------------------------
// booth_mul_ctrl : sequential radix-2 Booth signed multiplier, one step/cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module booth_mul_ctrl #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_ctrl_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [N:0]     acc;
  logic [N:0]     mx;
  logic [N-1:0]   q;
  logic           q1;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] product_r;

  logic           load;
  logic           step;
  logic           last;
  logic           busy_w;
  logic           done_w;

  // Shared N+1-bit ripple adder/subtractor; carry-in 1 selects A - Mx
  logic           sub;
  logic [N:0]     b_op;
  logic [N:0]     sum;
  logic [N:0]     carry;

  assign sub      = q[0] & ~q1;
  assign b_op     = mx ^ {(N + 1){sub}};
  assign carry[0] = sub;

  generate
    for (genvar i = 0; i <= N; i++) begin : g_ripple
      assign sum[i] = acc[i] ^ b_op[i] ^ carry[i];
      if (i < N) begin : g_carry
        assign carry[i+1] = (acc[i] & b_op[i]) | (carry[i] & (acc[i] ^ b_op[i]));
      end
    end
  endgenerate

  // Booth pairs 00/11 discard the adder result
  logic [N:0]     acc_next;
  logic [2*N+1:0] shift_w;

  assign acc_next = (q[0] ^ q1) ? sum : acc;
  assign shift_w  = {acc_next[N], acc_next, q};
  assign last     = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy_w     = 1'b0;
    done_w     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_w = 1'b1;
        step   = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_w     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      mx        <= '0;
      q         <= '0;
      q1        <= 1'b0;
      cnt       <= '0;
      product_r <= '0;
    end else if (load) begin
      acc <= '0;
      mx  <= {bus.multiplicand[N-1], bus.multiplicand};
      q   <= bus.multiplier;
      q1  <= 1'b0;
      cnt <= CW'(N);
    end else if (step) begin
      acc <= shift_w[2*N+1:N+1];
      q   <= shift_w[N:1];
      q1  <= shift_w[0];
      cnt <= cnt - CW'(1);
      if (last) begin
        product_r <= shift_w[2*N:1];
      end
    end
  end

  assign bus.busy    = busy_w;
  assign bus.done    = done_w;
  assign bus.product = product_r;

endmodule

`default_nettype wire

// File: tb/tb_booth_mul_ctrl.sv
// ----------------------------------------------------------------------------
// tb_booth_mul_ctrl : scoreboard bench for booth_mul_ctrl (N = 4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_booth_mul_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  booth_mul_ctrl_if #(.N(N)) bus ();

  booth_mul_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [2*N-1:0] expq[$];
  int  done_cnt      = 0;
  int  cyc           = 0;
  int  last_done     = -1;
  bit  check_spacing = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_exclusive", 64'(bus.busy & bus.done), 64'd0);
      if (bus.done) begin
        done_cnt++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          check("product", 64'(bus.product), 64'(expq.pop_front()));
        end
        if (check_spacing && last_done >= 0)
          check("done_spacing", 64'(cyc - last_done), 64'(N + 2));
        last_done = cyc;
      end
    end
  end

  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] qv, input logic [2*N-1:0] exp);
    int lat;
    int busy_cycles;
    @(negedge clk);
    bus.multiplicand = m;
    bus.multiplier   = qv;
    bus.start        = 1'b1;
    expq.push_back(exp);
    @(negedge clk);
    bus.start   = 1'b0;
    lat         = 1;
    busy_cycles = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(N + 1));
    check("busy_cycles", 64'(busy_cycles), 64'(N));
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t vecs[4] = '{
    '{4'd3, 4'd5, 8'h0F},
    '{4'hD, 4'd5, 8'hF1},
    '{4'd7, 4'h8, 8'hC8},
    '{4'h8, 4'h8, 8'h40}
  };

  initial begin
    int dc0;
    int wait_cyc;
    logic signed [N-1:0]   ms;
    logic signed [N-1:0]   qs;
    logic signed [2*N-1:0] ps;

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    #12;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].p);

    // Start pulse and operand changes during RUN must be ignored
    dc0 = done_cnt;
    @(negedge clk);
    bus.multiplicand = 4'd2;
    bus.multiplier   = 4'd3;
    bus.start        = 1'b1;
    expq.push_back(8'h06);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.multiplicand = 4'd7;
    bus.multiplier   = 4'd7;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("single_done_pulse", 64'(done_cnt - dc0), 64'd1);

    // Asynchronous reset two cycles into RUN
    @(negedge clk);
    bus.multiplicand = 4'hB;
    bus.multiplier   = 4'd3;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dc0 = done_cnt;
    run_op(4'd0, 4'hF, 8'h00);
    check("post_reset_done_count", 64'(done_cnt - dc0), 64'd1);

    // Exhaustive sweep with start held high
    last_done     = -1;
    check_spacing = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ms = i[3:0];
      qs = i[7:4];
      ps = ms * qs;
      bus.multiplicand = ms;
      bus.multiplier   = qs;
      bus.start        = 1'b1;
      expq.push_back(ps);
      wait_cyc = 0;
      do begin
        @(negedge clk);
        wait_cyc++;
      end while (!bus.done && wait_cyc < 20);
      if (!bus.done) begin
        total++;
        bad++;
        $display("FAIL sweep_timeout actual=no_done required=done idx=%0d", i);
      end
      @(negedge clk);
    end
    bus.start     = 1'b0;
    check_spacing = 1'b0;
    repeat (10) @(negedge clk);

    check("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
